// File: rtl/fifo_word_packer_pkg.sv
// Shared types and widths for the byte-to-word packer slice.
// Latency: n/a (types, constants and one pure helper function only).
// Backpressure: n/a.
// Contents: pack_state_t FSM encoding, BYTE_W/WORD_W/CNT_W widths and
// lane_insert(), which writes one byte into a chosen lane of a word.
package fifo_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int CNT_W  = 2;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } pack_state_t;

  // Little-endian lane placement: lane 0 is bits [7:0].
  function automatic logic [WORD_W-1:0] lane_insert(
    input logic [WORD_W-1:0] word,
    input logic [CNT_W-1:0]  lane,
    input logic [BYTE_W-1:0] data
  );
    logic [WORD_W-1:0] w;
    w = word;
    w[{lane, 3'b000} +: BYTE_W] = data;
    return w;
  endfunction

endpackage

// File: rtl/fifo_word_packer_if.sv
// Bundles the FIFO read port and the word valid/ready port of the packer.
// Latency: n/a (wires only).
// Backpressure: word_ready from the sink; the FIFO side is throttled by rd.
// Signals: rd/empty/data_in (show-ahead FIFO read port),
// word_out/word_bytes/word_valid/word_ready (word sink).
// Modports: master = the packer, slave = the FIFO plus sink around it.
interface fifo_word_packer_if;
  import fifo_pkg::*;

  logic              rd;
  logic              empty;
  logic [BYTE_W-1:0] data_in;
  logic [WORD_W-1:0] word_out;
  logic [2:0]        word_bytes;
  logic              word_valid;
  logic              word_ready;

  modport master (
    output rd,
    input  empty,
    input  data_in,
    output word_out,
    output word_bytes,
    output word_valid,
    input  word_ready
  );

  modport slave (
    input  rd,
    output empty,
    output data_in,
    input  word_out,
    input  word_bytes,
    input  word_valid,
    output word_ready
  );

endinterface

// File: rtl/fifo_word_packer_idle_timer.sv
// Saturating idle counter; flags expiry on the TIMEOUT-th consecutive idle cycle.
// Latency: expired is combinational on the cycle the count reaches TIMEOUT.
// Backpressure: none; clr wins over inc.
// Ports: rd_clk, reset (sync, active-high), clr, inc, expired.
module pack_idle_timer #(
  parameter int TIMEOUT = 16
) (
  input  logic rd_clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge rd_clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CW'(TIMEOUT))) begin
      cnt <= cnt + CW'(1);
    end
  end

  // cnt holds the idle cycles already seen; this cycle is the TIMEOUT-th.
  assign expired = inc && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/fifo_word_packer.sv
// Pops a show-ahead byte FIFO and packs 4 bytes little-endian into a 32-bit word.
// Latency: word_valid rises 4 cycles after the first pop at full rate; 1 byte/cycle sustained.
// Backpressure: a stalled sink holds the word and drops rd; no byte is lost or duplicated.
// Ports: rd_clk, reset (sync, active-high), bus (fifo_word_packer_if.master).
// Option: define FLUSH_TIMEOUT_EN to flush a partial word after TIMEOUT idle cycles.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT        = 16
) (
  input  logic                 rd_clk,
  input  logic                 reset,
  fifo_word_packer_if.master   bus
);

  localparam logic [CNT_W-1:0] LAST_LANE  = CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [2:0]       FULL_BYTES = 3'(BYTES_PER_WORD);

  pack_state_t       state;
  logic [CNT_W-1:0]  byte_cnt;
  logic [WORD_W-1:0] word_q;
  logic [2:0]        bytes_q;
  logic              valid_q;
  logic              accept;
  logic              pop;

  assign accept = (state == HOLD) && bus.word_ready;
  // Popping while the held word leaves lets the next word start with no bubble.
  assign pop    = !reset && !bus.empty && ((state == FILL) || accept);

  assign bus.rd         = pop;
  assign bus.word_out   = word_q;
  assign bus.word_bytes = bytes_q;
  assign bus.word_valid = valid_q;

`ifdef FLUSH_TIMEOUT_EN
  logic idle;
  logic flush;

  // Idle means a partial word is waiting and nothing arrived this cycle.
  assign idle = (state == FILL) && (byte_cnt != '0) && !pop;

  pack_idle_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_idle_timer (
    .rd_clk  (rd_clk),
    .reset   (reset),
    .clr     (!idle),
    .inc     (idle),
    .expired (flush)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_ff @(posedge rd_clk) begin
    if (reset) begin
      state    <= FILL;
      byte_cnt <= '0;
      word_q   <= '0;
      bytes_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (pop) begin
            word_q   <= lane_insert(word_q, byte_cnt, bus.data_in);
            byte_cnt <= byte_cnt + CNT_W'(1);
            if (byte_cnt == LAST_LANE) begin
              state   <= HOLD;
              valid_q <= 1'b1;
              bytes_q <= FULL_BYTES;
            end
          end
`ifdef FLUSH_TIMEOUT_EN
          else if (flush) begin
            // Upper lanes were never written, so they are already zero.
            state    <= HOLD;
            valid_q  <= 1'b1;
            bytes_q  <= {1'b0, byte_cnt};
            byte_cnt <= '0;
          end
`endif
        end
        HOLD: begin
          if (bus.word_ready) begin
            state   <= FILL;
            valid_q <= 1'b0;
            bytes_q <= '0;
            if (pop) begin
              word_q   <= lane_insert('0, '0, bus.data_in);
              byte_cnt <= CNT_W'(1);
            end else begin
              word_q   <= '0;
              byte_cnt <= '0;
            end
          end
        end
        default: state <= FILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_word_packer.sv
// Directed plus random bench for fifo_word_packer with a byte scoreboard.
// Latency: n/a (bench).
// Backpressure: bench drives empty and word_ready, models a show-ahead FIFO.
module tb_fifo_word_packer;

  logic rd_clk = 1'b0;
  logic reset;
  always #5 rd_clk = ~rd_clk;

  fifo_word_packer_if bus ();

  fifo_word_packer dut (
    .rd_clk (rd_clk),
    .reset  (reset),
    .bus    (bus)
  );

  int n_assert;
  int n_fail;

  logic [7:0]  fifo_q[$];
  logic [7:0]  exp_q[$];
  logic [31:0] acc_word[$];
  logic [2:0]  acc_bytes[$];
  int          acc_cyc[$];

  logic reset_req, block_empty, ready_v;
  int   cyc, pops, words, valid_cnt;
  int   first_pop_cyc, last_pop_cyc, first_valid_cyc;

  logic        prev_hold;
  logic [31:0] prev_word;
  logic [2:0]  prev_bytes;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_stats();
    pops = 0; words = 0; valid_cnt = 0;
    first_pop_cyc = -1; last_pop_cyc = -1; first_valid_cyc = -1;
    acc_word.delete(); acc_bytes.delete(); acc_cyc.delete();
  endtask

  task automatic push_byte(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic score_word();
    int          nb;
    logic [31:0] expw;
    logic        under;
    nb = int'(bus.word_bytes);
    expw = '0;
    under = 1'b0;
`ifdef FLUSH_TIMEOUT_EN
    check("sb_word_bytes_range", 32'((nb >= 1) && (nb <= 4)), 1);
`else
    check("sb_word_bytes", bus.word_bytes, 4);
`endif
    if (nb > 4) nb = 4;
    for (int i = 0; i < nb; i++) begin
      if (exp_q.size() == 0) under = 1'b1;
      else expw[i*8 +: 8] = exp_q.pop_front();
    end
    check("sb_underflow", under, 0);
    check("sb_word", bus.word_out, expw);
  endtask

  // One clock: drive at negedge, sample 2ns later, then apply what the next posedge does.
  task automatic cycle();
    logic do_pop, do_acc;
    @(negedge rd_clk);
    reset          = reset_req;
    bus.word_ready = ready_v;
    bus.empty      = block_empty || (fifo_q.size() == 0);
    bus.data_in    = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
    #2;
    cyc++;
    if (reset) check("rd_low_in_reset", bus.rd, 0);
    else       check("rd_not_while_empty", bus.rd & bus.empty, 0);
    if (prev_hold && !reset) begin
      check("hold_word_stable", bus.word_out, prev_word);
      check("hold_bytes_stable", bus.word_bytes, prev_bytes);
      check("hold_valid_stable", bus.word_valid, 1);
    end
    do_pop = !reset && (bus.rd === 1'b1) && !bus.empty;
    do_acc = !reset && (bus.word_valid === 1'b1) && bus.word_ready;
    if (!reset && (bus.word_valid === 1'b1)) begin
      valid_cnt++;
      if (first_valid_cyc < 0) first_valid_cyc = cyc;
    end
    if (do_pop) begin
      void'(fifo_q.pop_front());
      pops++;
      if (first_pop_cyc < 0) first_pop_cyc = cyc;
      last_pop_cyc = cyc;
    end
    if (do_acc) begin
      words++;
      acc_word.push_back(bus.word_out);
      acc_bytes.push_back(bus.word_bytes);
      acc_cyc.push_back(cyc);
      score_word();
    end
    prev_hold  = !reset && (bus.word_valid === 1'b1) && !bus.word_ready;
    prev_word  = bus.word_out;
    prev_bytes = bus.word_bytes;
  endtask

  task automatic do_reset();
    fifo_q.delete();
    exp_q.delete();
    reset_req = 1'b1;
    block_empty = 1'b0;
    ready_v = 1'b1;
    repeat (2) cycle();
    reset_req = 1'b0;
    prev_hold = 1'b0;
    clear_stats();
  endtask

  task automatic wait_words(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while ((words < n) && (k < budget)) begin
      cycle();
      k++;
    end
    check(tag, 32'(words >= n), 1);
  endtask

  initial begin
    int k;
    int pushed;
    n_assert = 0; n_fail = 0; cyc = 0;
    reset = 1'b1; reset_req = 1'b1; block_empty = 1'b0; ready_v = 1'b1;
    bus.empty = 1'b1; bus.data_in = 8'h00; bus.word_ready = 1'b0;
    prev_hold = 1'b0; prev_word = '0; prev_bytes = '0;
    clear_stats();

    // Reset state
    do_reset();
    check("rst_word_valid", bus.word_valid, 0);
    check("rst_word_out", bus.word_out, 0);
    check("rst_word_bytes", bus.word_bytes, 0);

    // 1: four bytes, sink always ready
    push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
    wait_words(1, 40, "t1_word_timeout");
    repeat (4) cycle();
    check("t1_pops", pops, 4);
    check("t1_word", acc_word[0], 32'h44332211);
    check("t1_bytes", acc_bytes[0], 4);
    check("t1_latency", first_valid_cyc - first_pop_cyc, 4);
    check("t1_valid_one_cycle", valid_cnt, 1);
    check("t1_lanes_cleared", bus.word_out, 0);

    // 2: eight bytes, sink stalled for 10 cycles on the first word
    do_reset();
    ready_v = 1'b0;
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    k = 0;
    while ((first_valid_cyc < 0) && (k < 40)) begin cycle(); k++; end
    check("t2_valid_seen", 32'(first_valid_cyc >= 0), 1);
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("t2_rd_low_in_hold", bus.rd, 0);
      check("t2_word_held", bus.word_out, 32'h04030201);
    end
    ready_v = 1'b1;
    wait_words(2, 40, "t2_word_timeout");
    check("t2_word0", acc_word[0], 32'h04030201);
    check("t2_word1", acc_word[1], 32'h08070605);
    check("t2_no_bubble", acc_cyc[1] - acc_cyc[0], 4);
    check("t2_pops", pops, 8);

    // 3: FIFO empty throughout, sink ready toggling
    do_reset();
    block_empty = 1'b1;
    for (int i = 0; i < 24; i++) begin
      ready_v = (i % 2) == 0;
      cycle();
    end
    check("t3_pops", pops, 0);
    check("t3_valid", valid_cnt, 0);
    block_empty = 1'b0;
    ready_v = 1'b1;

    // 4: reset after two of four bytes, then a fresh word
    do_reset();
    push_byte(8'hA1); push_byte(8'hA2); push_byte(8'hA3); push_byte(8'hA4);
    cycle(); cycle();
    check("t4_pops_before_reset", pops, 2);
    do_reset();
    push_byte(8'h5A); push_byte(8'h6B); push_byte(8'h7C); push_byte(8'h8D);
    wait_words(1, 40, "t4_word_timeout");
    check("t4_fresh_word", acc_word[0], 32'h8D7C6B5A);
    check("t4_bytes", acc_bytes[0], 4);

    // 5: three bytes then the FIFO runs dry
    do_reset();
    push_byte(8'hAA); push_byte(8'hBB); push_byte(8'hCC);
    repeat (30) cycle();
    check("t5_pops", pops, 3);
`ifdef FLUSH_TIMEOUT_EN
    check("t5_words", words, 1);
    check("t5_word", acc_word[0], 32'h00CCBBAA);
    check("t5_bytes", acc_bytes[0], 3);
    check("t5_flush_delay", first_valid_cyc - last_pop_cyc, 17);
`else
    check("t5_words", words, 0);
    check("t5_valid", valid_cnt, 0);
`endif

    // 6: random empty and ready over 1000 bytes
    do_reset();
    pushed = 0;
    k = 0;
    while (((pushed < 1000) || (exp_q.size() != 0)) && (k < 20000)) begin
      if (pushed < 1000) begin
        if ((fifo_q.size() < 12) && ($urandom_range(0, 3) != 0)) begin
          push_byte(8'($urandom));
          pushed++;
        end
        block_empty = ($urandom_range(0, 3) == 0);
        ready_v = ($urandom_range(0, 2) != 0);
      end else begin
        block_empty = 1'b0;
        ready_v = 1'b1;
      end
      cycle();
      k++;
    end
    check("t6_sb_drained", exp_q.size(), 0);
    check("t6_fifo_drained", fifo_q.size(), 0);
    check("t6_pops", pops, 1000);
`ifndef FLUSH_TIMEOUT_EN
    check("t6_words", words, 250);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
